// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter encodings and opcode constant for the branch predictor
package bp_pkg;

  localparam logic [1:0] CNT_SNT   = 2'b00;
  localparam logic [1:0] CNT_WNT   = 2'b01;
  localparam logic [1:0] CNT_WT    = 2'b10;
  localparam logic [1:0] CNT_ST    = 2'b11;
  localparam logic [1:0] CNT_RESET = CNT_WNT;
  localparam logic [1:0] CNT_ALLOC = CNT_WT;

  localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - 2-bit saturating counter next-state
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - direct-mapped BHT/BTB lookup at fetch, update and redirect at execute
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] if_pc_i,
  output logic        pred_hit_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          cnt_q    [ENTRIES];

  logic        mispredict_q;
  logic [31:0] redirect_q;
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;
  logic                resolve;
  logic                mispredict;
  logic [31:0]         ex_fallthrough;
  logic [1:0]          cnt_next;
  logic                unused_pc_bits;

  assign if_idx = if_pc_i[IDX_BITS+1:2];
  assign if_tag = if_pc_i[IDX_BITS+2 +: TAG_BITS];
  assign ex_idx = ex_pc_i[IDX_BITS+1:2];
  assign ex_tag = ex_pc_i[IDX_BITS+2 +: TAG_BITS];

  assign unused_pc_bits = ^{if_pc_i[1:0], if_pc_i[31:IDX_BITS+2+TAG_BITS]};

  // Lookup reads the flops directly; updates land only after the edge.
  assign pred_hit_o    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken_o  = pred_hit_o && cnt_q[if_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[if_idx] : if_pc_i + 32'd4;

  // The instruction in EX while a redirect is out is wrong-path.
  assign resolve        = ex_valid_i && ex_is_branch_i && !mispredict_q;
  assign ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_fallthrough = ex_pc_i + 32'd4;
  assign mispredict     = resolve && (ex_taken_i ? (ex_pred_target_i != ex_target_i)
                                                 : ex_pred_taken_i);

  bp_sat_counter u_sat_counter (
    .cnt      (cnt_q[ex_idx]),
    .taken    (ex_taken_i),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RESET;
      end
    end else if (resolve) begin
      if (ex_hit) begin
        cnt_q[ex_idx] <= cnt_next;
        if (ex_taken_i) target_q[ex_idx] <= ex_target_i;
      end else if (ex_taken_i) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target_i;
        cnt_q[ex_idx]    <= CNT_ALLOC;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mispredict_q  <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      mispredict_q <= mispredict;
      if (resolve) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict) begin
        redirect_q    <= ex_taken_i ? ex_target_i : ex_fallthrough;
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign mispredict_o  = mispredict_q;
  assign redirect_pc_o = redirect_q;
  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - directed self-checking bench for branch_predictor_bht
module tb_branch_predictor_bht;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] if_pc_i;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i;
  logic        ex_is_branch_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  branch_predictor_bht #(.IDX_BITS(6), .TAG_BITS(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .if_pc_i          (if_pc_i),
    .pred_hit_o       (pred_hit_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .ex_valid_i       (ex_valid_i),
    .ex_is_branch_i   (ex_is_branch_i),
    .ex_pc_i          (ex_pc_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
    .mispredict_o     (mispredict_o),
    .redirect_pc_o    (redirect_pc_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic ex_drive(input logic v, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid_i       = v;
    ex_is_branch_i   = v;
    ex_pc_i          = pc;
    ex_taken_i       = tk;
    ex_target_i      = tgt;
    ex_pred_taken_i  = ptk;
    ex_pred_target_i = ptgt;
  endtask

  task automatic chk_pred(input string tag, input logic hit, input logic tk, input logic [31:0] tgt);
    chk({tag, "_hit"},    {31'd0, pred_hit_o},   {31'd0, hit});
    chk({tag, "_taken"},  {31'd0, pred_taken_o}, {31'd0, tk});
    chk({tag, "_target"}, pred_target_o, tgt);
  endtask

  task automatic chk_out(input string tag, input logic mp, input logic [31:0] rd,
                         input logic [31:0] bc, input logic [31:0] mc);
    chk({tag, "_mp"},    {31'd0, mispredict_o}, {31'd0, mp});
    chk({tag, "_redir"}, redirect_pc_o, rd);
    chk({tag, "_bcnt"},  branch_cnt_o, bc);
    chk({tag, "_mcnt"},  mispred_cnt_o, mc);
  endtask

  initial begin
    rst_ni  = 1'b0;
    if_pc_i = 32'h100;
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk_pred("reset", 1'b0, 1'b0, 32'h104);
    chk_out("reset", 1'b0, 32'h0, 32'd0, 32'd0);
    tick();
    tick();
    rst_ni = 1'b1;

    // taken branch predicted NT: allocate and redirect
    ex_drive(1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    tick();
    chk_out("alloc", 1'b1, 32'h40, 32'd1, 32'd1);
    chk_pred("alloc", 1'b1, 1'b1, 32'h40);

    // shadow cycle: a different taken branch must be ignored
    ex_drive(1'b1, 32'h200, 1'b1, 32'h80, 1'b0, 32'h204);
    tick();
    chk_out("shadow", 1'b0, 32'h40, 32'd1, 32'd1);
    if_pc_i = 32'h200;
    #1;
    chk_pred("shadow", 1'b0, 1'b0, 32'h204);
    if_pc_i = 32'h100;

    // not-taken x4: 10 -> 01 -> 00 -> 00
    ex_drive(1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
    tick();
    chk_out("nt1", 1'b1, 32'h104, 32'd2, 32'd2);
    chk_pred("nt1", 1'b1, 1'b0, 32'h104);
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("nt1_idle", 1'b0, 32'h104, 32'd2, 32'd2);
    ex_drive(1'b1, 32'h100, 1'b0, 32'h40, 1'b0, 32'h104);
    tick();
    chk_out("nt2", 1'b0, 32'h104, 32'd3, 32'd2);
    tick();
    chk_out("nt3", 1'b0, 32'h104, 32'd4, 32'd2);
    tick();
    chk_out("nt4", 1'b0, 32'h104, 32'd5, 32'd2);
    chk_pred("nt4", 1'b1, 1'b0, 32'h104);

    // one taken from saturated 00 reaches only 01: still predicts NT
    ex_drive(1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    tick();
    chk_out("sat", 1'b1, 32'h40, 32'd6, 32'd3);
    chk_pred("sat", 1'b1, 1'b0, 32'h104);
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // aliasing: 0x200 shares the index of 0x100 with a different tag
    ex_drive(1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h300);
    tick();
    chk_out("alias", 1'b0, 32'h40, 32'd7, 32'd3);
    chk_pred("alias_old", 1'b0, 1'b0, 32'h104);
    if_pc_i = 32'h200;
    #1;
    chk_pred("alias_new", 1'b1, 1'b1, 32'h300);

    // correct direction, wrong target is a mispredict
    ex_drive(1'b1, 32'h200, 1'b1, 32'h340, 1'b1, 32'h300);
    tick();
    chk_out("tgt", 1'b1, 32'h340, 32'd8, 32'd4);
    chk_pred("tgt", 1'b1, 1'b1, 32'h340);
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // fall-through redirect wraps to zero; NT miss does not allocate
    ex_drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10);
    tick();
    chk_out("wrap", 1'b1, 32'h0, 32'd9, 32'd5);
    if_pc_i = 32'hFFFF_FFFC;
    #1;
    chk_pred("wrap", 1'b0, 1'b0, 32'h0);
    if_pc_i = 32'h200;
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // async reset with a mispredict pending
    ex_drive(1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h404);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_out("arst", 1'b0, 32'h0, 32'd0, 32'd0);
    chk_pred("arst", 1'b0, 1'b0, 32'h204);
    tick();
    chk_out("arst_hold", 1'b0, 32'h0, 32'd0, 32'd0);
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_ni = 1'b1;
    tick();

    // branch counter wraps modulo 2**32
    dut.branch_cnt_q = 32'hFFFF_FFFF;
    ex_drive(1'b1, 32'h100, 1'b0, 32'h40, 1'b0, 32'h104);
    tick();
    chk_out("cwrap", 1'b0, 32'h0, 32'd0, 32'd0);
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
